// File: rtl/cache.sv
// Direct-mapped, word-addressed write-allocate cache: 32 lines x 8 words x 16 bits.
// No backing store; read misses return zero and never allocate.
module cache (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Address,
    input  logic [15:0] Data_In,
    input  logic        Write_Enable,
    output logic [15:0] Data_Out,
    output logic        Miss
);
    localparam int LINES = 32;
    localparam int WORDS = 8;

    logic [LINES-1:0]                   valid_q;
    logic [LINES-1:0][7:0]              tag_q;
    logic [LINES-1:0][WORDS-1:0][15:0]  data_q;

    logic [7:0]              tag;
    logic [4:0]              idx;
    logic [2:0]              off;
    logic                    hit;
    logic [WORDS-1:0][15:0]  line_d;

    assign tag = Address[15:8];
    assign idx = Address[7:3];
    assign off = Address[2:0];

    // Gating with rst keeps outputs at their reset values while reset is held.
    assign hit      = !rst && valid_q[idx] && (tag_q[idx] == tag);
    assign Miss     = !hit;
    assign Data_Out = hit ? data_q[idx][off] : 16'h0000;

    // A miss starts from an all-zero line, so the other seven words clear on allocation.
    always_comb begin
        line_d      = hit ? data_q[idx] : '0;
        line_d[off] = Data_In;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (Write_Enable) begin
            valid_q[idx] <= 1'b1;
            tag_q[idx]   <= tag;
            data_q[idx]  <= line_d;
        end
    end
endmodule

// File: tb/tb_cache.sv
// Directed table-driven bench for cache: vectors of {inputs, expected Miss/Data_Out}.
module tb_cache;
    logic        clk;
    logic        rst;
    logic [15:0] Address;
    logic [15:0] Data_In;
    logic        Write_Enable;
    logic [15:0] Data_Out;
    logic        Miss;

    int checks = 0;
    int errors = 0;

    cache dut (
        .clk          (clk),
        .rst          (rst),
        .Address      (Address),
        .Data_In      (Data_In),
        .Write_Enable (Write_Enable),
        .Data_Out     (Data_Out),
        .Miss         (Miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_miss;
        logic [15:0] exp_dout;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic we, input logic [15:0] addr, input logic [15:0] din,
                                input logic em, input logic [15:0] ed, input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.din = din; v.exp_miss = em; v.exp_dout = ed; v.name = name;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] addr, input logic [15:0] act_d,
                       input logic act_m, input logic [15:0] exp_d, input logic exp_m);
        checks++;
        if (act_d !== exp_d || act_m !== exp_m) begin
            errors++;
            $display("FAIL %s addr=%h: got Miss=%b Data_Out=%h, want Miss=%b Data_Out=%h",
                     name, addr, act_m, act_d, exp_m, exp_d);
        end
    endtask

    // Drive at the falling edge, sample 1ns later; any write commits at the next rising edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        Write_Enable = v.we;
        Address      = v.addr;
        Data_In      = v.din;
        #1;
        chk(v.name, v.addr, Data_Out, Miss, v.exp_dout, v.exp_miss);
    endtask

    initial begin
        rst = 1'b1; Write_Enable = 1'b0; Address = 16'h0000; Data_In = 16'h0000;

        // Outputs during reset, with a write attempt that must be ignored.
        #2;
        chk("rst_hold", Address, Data_Out, Miss, 16'h0000, 1'b1);
        Write_Enable = 1'b1; Address = 16'h1812; Data_In = 16'hFFFF;
        @(posedge clk); #1;
        chk("rst_write_ignored", Address, Data_Out, Miss, 16'h0000, 1'b1);
        @(negedge clk);
        Write_Enable = 1'b0;
        rst = 1'b0;

        add(0, 16'h1812, 16'h0, 1, 16'h0, "read_after_rst");
        add(0, 16'h1812, 16'h0, 1, 16'h0, "read_no_alloc");
        add(0, 16'hFFFF, 16'h0, 1, 16'h0, "read_ffff");
        for (int i = 0; i < 10; i++)
            add(1, 16'h1812 + 16'(i), 16'(i + 1), (i == 0 || i == 6), 16'h0, "wr_seq1");
        for (int i = 0; i < 10; i++)
            add(0, 16'h1812 + 16'(i), 16'h0, 0, 16'(i + 1), "rd_seq1");
        add(0, 16'h1810, 16'h0, 0, 16'h0, "cleared_1810");
        add(0, 16'h1811, 16'h0, 0, 16'h0, "cleared_1811");
        add(0, 16'h181C, 16'h0, 0, 16'h0, "cleared_181c");
        for (int i = 0; i < 10; i++)
            add(1, 16'h1902 + 16'(i), 16'(i + 11), (i == 0 || i == 6), 16'h0, "wr_seq2");
        for (int i = 0; i < 10; i++)
            add(0, 16'h1902 + 16'(i), 16'h0, 0, 16'(i + 11), "rd_seq2");
        add(0, 16'h1900, 16'h0, 0, 16'h0, "cleared_1900");
        add(0, 16'h1800, 16'h0, 1, 16'h0, "tag_mismatch_1800");
        for (int i = 0; i < 10; i++)
            add(0, 16'h1812 + 16'(i), 16'h0, 0, 16'(i + 1), "seq1_intact");
        for (int k = 1; k <= 20; k++)
            add(0, 16'h1001 + 16'(129 * k), 16'h0, (k != 16), 16'h0, "stride");
        // Write hit: Data_Out shows the pre-write word during the write cycle.
        add(1, 16'h1819, 16'h5555, 0, 16'h0008, "wr_hit_prewrite");
        add(0, 16'h1819, 16'h0, 0, 16'h5555, "wr_hit_result");
        add(0, 16'h181A, 16'h0, 0, 16'h0009, "wr_hit_neighbor");
        add(1, 16'h2010, 16'hABCD, 1, 16'h0, "evict_write");
        add(0, 16'h1812, 16'h0, 1, 16'h0, "evicted_1812");
        add(0, 16'h2010, 16'h0, 0, 16'hABCD, "evict_new");
        add(0, 16'h2011, 16'h0, 0, 16'h0, "evict_cleared");
        add(0, 16'h1818, 16'h0, 0, 16'h0007, "other_idx_intact");

        foreach (vq[i]) step(vq[i]);

        // Async reset between edges, with a write pending on the next edge.
        @(negedge clk);
        Write_Enable = 1'b1; Address = 16'h2010; Data_In = 16'h1234;
        #2;
        chk("pre_rst_hit", Address, Data_Out, Miss, 16'hABCD, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_immediate", Address, Data_Out, Miss, 16'h0000, 1'b1);
        @(posedge clk); #1;
        chk("rst_mid_write", Address, Data_Out, Miss, 16'h0000, 1'b1);
        @(negedge clk);
        Write_Enable = 1'b0;
        rst = 1'b0;

        vq.delete();
        add(0, 16'h2010, 16'h0, 1, 16'h0, "post_rst_2010");
        add(0, 16'h1818, 16'h0, 1, 16'h0, "post_rst_1818");
        add(0, 16'h1811, 16'h0, 1, 16'h0, "post_rst_1811");
        add(0, 16'h1905, 16'h0, 1, 16'h0, "post_rst_1905");
        add(0, 16'h190B, 16'h0, 1, 16'h0, "post_rst_190b");
        add(0, 16'h0000, 16'h0, 1, 16'h0, "post_rst_0000");
        // Tag 0 at index 0 after reset must still miss: valid bits gate the hit.
        add(1, 16'h0003, 16'h00AA, 1, 16'h0, "first_write_after_rst");
        add(0, 16'h0003, 16'h0, 0, 16'h00AA, "first_write_read");
        foreach (vq[i]) step(vq[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache.md
# cache

Direct-mapped, word-addressed data cache holding 32 lines of 8 × 16-bit words, with a single-port read/write access interface and a hit/miss indication. It has no backing-memory interface: lines are allocated only by writes, and read misses return zero without side effects. It sits between a processor memory stage and the memory system, and is exercised stand-alone.

## Interface
- No parameters; geometry is fixed: 32 lines, 8 words/line, 16-bit words.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Address  in  16  word address; tag = [15:8], index = [7:3], offset = [2:0].
- Data_In  in  16  write data.
- Write_Enable  in  1  1 = write the addressed word at the next rising clk; 0 = read.
- Data_Out  out  16  read data for Address (combinational).
- Miss  out  1  1 when the addressed line is invalid or its tag mismatches (combinational).

## Operation
- Storage per line: valid bit, 8-bit tag, 8 data words.
- Hit condition: valid[index] && tag[index] == Address[15:8]. Miss = !hit, regardless of Write_Enable.
- Read (Write_Enable=0):
  - Hit: Data_Out = data[index][offset].
  - Miss: Data_Out = 16'h0000.
  - Reads never change state.
- Write hit: data[index][offset] ← Data_In; tag and valid are unchanged.
- Write miss (write-allocate, no write-back):
  - tag[index] ← Address[15:8]; valid[index] ← 1.
  - data[index][offset] ← Data_In.
  - The other 7 words of the line are cleared to 0.
  - The previous line contents are discarded.
- Data_Out while Write_Enable=1 follows the read rules using pre-write state.
- Address and Data_In are used at full 16-bit width; no byte enables and no alignment restrictions.

## Timing
- Reads and Miss are combinational from Address and the current array state; zero-cycle latency.
- Writes commit on the rising clk edge where Write_Enable=1. Miss and Data_Out reflect the new state after that edge.
- A sequence of writes to consecutive addresses, one per cycle, is fully supported. The first write into a new line misses and allocates; later writes in the same line hit.
- Reset (asynchronous, any time, including mid-write): all valid bits ← 0, all tags ← 0, all data ← 0.
- While rst=1, writes are ignored, Miss = 1 and Data_Out = 0.
- After reset deasserts, the first rising edge may write.
- Reset values: Miss = 1, Data_Out = 16'h0000.

## Test plan
- Reset → for any Address, Miss=1 and Data_Out=0; a read to 16'h1812 does not allocate (Miss stays 1).
- Write sequence:
  - Stimulus: Data_In 1..10 to Address 16'h1812..16'h181B, one per cycle.
  - Miss=1 during the 16'h1812 and 16'h1818 cycles (allocation), Miss=0 during the others.
  - Read-back of 16'h1812..16'h181B returns 1..10 with Miss=0.
  - Read of 16'h1810 and 16'h1811 returns 0 with Miss=0 (cleared on allocation).
- Second region:
  - Stimulus: write 11..20 to 16'h1902..16'h190B.
  - Read-back returns 11..20, Miss=0.
  - The 16'h181x data is intact (different index).
- Stride read: read 16'h1001 + 129·k for k=1..20 → only k=16 (16'h1811) has Miss=0; all others Miss=1 with Data_Out=0.
- Conflict eviction:
  - Write 16'hABCD to 16'h2010 (index 2, tag 0x20) → Miss=1 during the write.
  - Afterwards, 16'h1812 reads Miss=1 and Data_Out=0.
  - 16'h2010 reads 16'hABCD with Miss=0.
- Async reset mid-sequence:
  - Assert rst between clock edges after the writes.
  - Miss goes to 1 immediately; all earlier addresses read Miss=1 and Data_Out=0 after release.
